// File: rtl/swd_pkg.sv
// rtl/swd_pkg.sv - shared SWD phase encodings, phase lengths and acknowledge codes
package swd_pkg;

   // Phase encoding as seen on the phase output.
   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_REQ  = 3'd1,
      PH_TRN1 = 3'd2,
      PH_ACK  = 3'd3,
      PH_TRN2 = 3'd4,
      PH_DATA = 3'd5,
      PH_PAR  = 3'd6,
      PH_TRN3 = 3'd7
   } phase_e;

   // Fixed phase lengths in SWCLK bits; turnaround length is a top-level parameter.
   localparam int REQ_BITS  = 8;
   localparam int ACK_BITS  = 3;
   localparam int DATA_BITS = 32;
   localparam int PAR_BITS  = 1;

   // Acknowledge codes returned by the target.
   localparam logic [2:0] ACK_OK    = 3'b001;
   localparam logic [2:0] ACK_WAIT  = 3'b010;
   localparam logic [2:0] ACK_FAULT = 3'b100;

   // Host owns SWDIO during the request and, for writes, during data and parity.
   function automatic logic host_drives(input phase_e ph, input logic rnw);
      return (ph == PH_REQ) || (((ph == PH_DATA) || (ph == PH_PAR)) && !rnw);
   endfunction

endpackage

// File: rtl/swd_bit_cnt.sv
// rtl/swd_bit_cnt.sv - 4-bit synchronous counter slice with clear, enable and carry-out
module swd_bit_cnt (
   input  logic       clk_i,
   input  logic       clr_n_i,
   input  logic       sclr_i,
   input  logic       en_i,
   output logic [3:0] q_o,
   output logic       co_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Synchronous clear wins over enable so a phase change always restarts at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (sclr_i) begin
         cnt_d = 4'd0;
      end else if (en_i) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q_o  = cnt_q;
   // Carry enables the next slice on the increment that wraps this one.
   assign co_o = en_i && (cnt_q == 4'hF);

endmodule

// File: rtl/swd_phase_ctrl.sv
// rtl/swd_phase_ctrl.sv - SWD transaction phase sequencer driving direction and shift strobes
module swd_phase_ctrl #(
   parameter int         TRN_CYCLES = 1,
   parameter logic [2:0] ACK_OK     = swd_pkg::ACK_OK
) (
   input  logic       clk_i,
   input  logic       clr_n_i,
   input  logic       bit_tick_i,
   input  logic       start_i,
   input  logic       rnw_i,
   input  logic [2:0] ack_i,
   output logic       busy_o,
   output logic [2:0] phase_o,
   output logic [5:0] bit_idx_o,
   output logic       swdio_oe_o,
   output logic       shift_en_o,
   output logic       done_o,
   output logic [2:0] status_o
);

   import swd_pkg::*;

   phase_e     phase_q, phase_d;
   logic       rnw_q, rnw_d;
   logic       busy_q, busy_d;
   logic       oe_q, oe_d;
   logic       done_q, done_d;
   logic [2:0] status_q, status_d;

   logic [7:0] cnt;
   logic [7:0] last_idx;
   logic       last_bit;
   logic       cnt_sclr;
   logic       cnt_en;
   logic       cnt_lo_co;
   logic       cnt_hi_co_unused;

   // Two cascaded 4-bit slices form the 8-bit in-phase bit counter.
   swd_bit_cnt u_cnt_lo (
      .clk_i   (clk_i),
      .clr_n_i (clr_n_i),
      .sclr_i  (cnt_sclr),
      .en_i    (cnt_en),
      .q_o     (cnt[3:0]),
      .co_o    (cnt_lo_co)
   );

   swd_bit_cnt u_cnt_hi (
      .clk_i   (clk_i),
      .clr_n_i (clr_n_i),
      .sclr_i  (cnt_sclr),
      .en_i    (cnt_lo_co),
      .q_o     (cnt[7:4]),
      .co_o    (cnt_hi_co_unused)
   );

   // Index of the final bit of the current phase.
   always_comb begin
      last_idx = 8'd0;
      case (phase_q)
         PH_REQ:                    last_idx = 8'(REQ_BITS - 1);
         PH_TRN1, PH_TRN2, PH_TRN3: last_idx = 8'(TRN_CYCLES - 1);
         PH_ACK:                    last_idx = 8'(ACK_BITS - 1);
         PH_DATA:                   last_idx = 8'(DATA_BITS - 1);
         PH_PAR:                    last_idx = 8'(PAR_BITS - 1);
         default:                   last_idx = 8'd0;
      endcase
   end

   assign last_bit = (cnt == last_idx);

   // Next-state: accept in IDLE, otherwise advance one bit per tick and hop phase on the last bit.
   always_comb begin
      phase_d  = phase_q;
      rnw_d    = rnw_q;
      status_d = status_q;
      done_d   = 1'b0;
      cnt_sclr = 1'b0;
      cnt_en   = bit_tick_i && (phase_q != PH_IDLE);
      if (phase_q == PH_IDLE) begin
         // Counter held at zero, so a tick coinciding with start is not a REQ bit.
         cnt_sclr = 1'b1;
         if (start_i) begin
            phase_d = PH_REQ;
            rnw_d   = rnw_i;
         end
      end else if (bit_tick_i && last_bit) begin
         cnt_sclr = 1'b1;
         case (phase_q)
            PH_REQ:  phase_d = PH_TRN1;
            PH_TRN1: phase_d = PH_ACK;
            PH_ACK: begin
               status_d = ack_i;
               if (ack_i != ACK_OK) begin
                  phase_d = PH_TRN3;
               end else if (rnw_q) begin
                  phase_d = PH_DATA;
               end else begin
                  phase_d = PH_TRN2;
               end
            end
            PH_TRN2: phase_d = PH_DATA;
            PH_DATA: phase_d = PH_PAR;
            PH_PAR:  phase_d = rnw_q ? PH_TRN3 : PH_IDLE;
            default: phase_d = PH_IDLE;
         endcase
         done_d = (phase_d == PH_IDLE);
      end
      busy_d = (phase_d != PH_IDLE);
      oe_d   = host_drives(phase_d, rnw_d);
   end

   // State and registered outputs; reset aborts any transaction without a done pulse.
   always_ff @(posedge clk_i or negedge clr_n_i) begin
      if (!clr_n_i) begin
         phase_q  <= PH_IDLE;
         rnw_q    <= 1'b0;
         busy_q   <= 1'b0;
         oe_q     <= 1'b0;
         done_q   <= 1'b0;
         status_q <= 3'b000;
      end else begin
         phase_q  <= phase_d;
         rnw_q    <= rnw_d;
         busy_q   <= busy_d;
         oe_q     <= oe_d;
         done_q   <= done_d;
         status_q <= status_d;
      end
   end

   assign busy_o     = busy_q;
   assign phase_o    = phase_q;
   assign bit_idx_o  = cnt[5:0];
   assign swdio_oe_o = oe_q;
   assign done_o     = done_q;
   assign status_o   = status_q;
   assign shift_en_o = bit_tick_i && ((phase_q == PH_REQ) || (phase_q == PH_ACK) ||
                                      (phase_q == PH_DATA) || (phase_q == PH_PAR));

endmodule

// File: tb/tb_swd_phase_ctrl.sv
// tb/tb_swd_phase_ctrl.sv - directed table-driven bench for swd_phase_ctrl
module tb_swd_phase_ctrl;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       bit_tick;
   logic       start_a, start_b;
   logic       rnw;
   logic [2:0] ack;

   logic       busy_a, oe_a, sh_a, done_a;
   logic [2:0] phase_a, status_a;
   logic [5:0] idx_a;
   logic       busy_b, oe_b, sh_b, done_b;
   logic [2:0] phase_b, status_b;
   logic [5:0] idx_b;

   logic       sel;
   logic       busy_m, oe_m, sh_m, done_m;
   logic [2:0] phase_m, status_m;
   logic [5:0] idx_m;
   logic       sh_seen, oe_seen;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   swd_phase_ctrl #(.TRN_CYCLES(1), .ACK_OK(3'b001)) u_dut_a (
      .clk_i(clk), .clr_n_i(clr_n), .bit_tick_i(bit_tick), .start_i(start_a),
      .rnw_i(rnw), .ack_i(ack), .busy_o(busy_a), .phase_o(phase_a),
      .bit_idx_o(idx_a), .swdio_oe_o(oe_a), .shift_en_o(sh_a),
      .done_o(done_a), .status_o(status_a)
   );

   swd_phase_ctrl #(.TRN_CYCLES(3), .ACK_OK(3'b001)) u_dut_b (
      .clk_i(clk), .clr_n_i(clr_n), .bit_tick_i(bit_tick), .start_i(start_b),
      .rnw_i(rnw), .ack_i(ack), .busy_o(busy_b), .phase_o(phase_b),
      .bit_idx_o(idx_b), .swdio_oe_o(oe_b), .shift_en_o(sh_b),
      .done_o(done_b), .status_o(status_b)
   );

   assign busy_m   = sel ? busy_b   : busy_a;
   assign oe_m     = sel ? oe_b     : oe_a;
   assign sh_m     = sel ? sh_b     : sh_a;
   assign done_m   = sel ? done_b   : done_a;
   assign phase_m  = sel ? phase_b  : phase_a;
   assign status_m = sel ? status_b : status_a;
   assign idx_m    = sel ? idx_b    : idx_a;

   typedef struct {
      logic        sel;
      logic        rnw;
      logic [2:0]  ack;
      int          ticks;
      logic [31:0] seq;
      int          oe;
      int          sh;
      logic [2:0]  status;
      int          trnmax;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // One clock: inputs applied after the previous edge, strobes sampled before the next edge.
   task automatic step(input logic tk, input logic sa, input logic sb);
      bit_tick = tk;
      start_a  = sa;
      start_b  = sb;
      #1;
      sh_seen = sh_m;
      oe_seen = oe_m;
      @(posedge clk);
      #1;
      bit_tick = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
   endtask

   task automatic run_to_done(output int ticks, output logic [31:0] seq, output int oe,
                              output int sh, output int trnmax, output bit got_done);
      logic [2:0] last_ph;
      ticks    = 0;
      oe       = 0;
      sh       = 0;
      trnmax   = 0;
      got_done = 1'b0;
      last_ph  = phase_m;
      seq      = 32'(phase_m);
      for (int i = 0; i < 200 && !got_done; i++) begin
         step(1'b1, 1'b0, 1'b0);
         ticks++;
         if (oe_seen) oe++;
         if (sh_seen) sh++;
         if (phase_m != last_ph) begin
            seq     = (seq << 4) | 32'(phase_m);
            last_ph = phase_m;
         end
         if ((phase_m == 3'd2 || phase_m == 3'd4 || phase_m == 3'd7) && int'(idx_m) > trnmax)
            trnmax = int'(idx_m);
         if (done_m) got_done = 1'b1;
         else step(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int          ticks, oe, sh, trnmax;
      logic [31:0] seq;
      bit          got;
      bit          reached;

      vt[0] = '{1'b0, 1'b1, 3'b001, 46, 32'h1235670,  8, 44, 3'b001, 0};
      vt[1] = '{1'b0, 1'b0, 3'b001, 46, 32'h1234560, 41, 44, 3'b001, 0};
      vt[2] = '{1'b0, 1'b1, 3'b010, 13, 32'h12370,    8, 11, 3'b010, 0};
      vt[3] = '{1'b0, 1'b0, 3'b100, 13, 32'h12370,    8, 11, 3'b100, 0};
      vt[4] = '{1'b1, 1'b1, 3'b001, 50, 32'h1235670,  8, 44, 3'b001, 2};
      vt[5] = '{1'b1, 1'b0, 3'b001, 50, 32'h1234560, 41, 44, 3'b001, 2};
      vt[6] = '{1'b1, 1'b1, 3'b010, 17, 32'h12370,    8, 11, 3'b010, 2};

      sel = 1'b0; clr_n = 1'b0; bit_tick = 1'b0; start_a = 1'b0; start_b = 1'b0;
      rnw = 1'b0; ack = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_phase", int'(phase_a), 0);
      chk("rst_bit_idx", int'(idx_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_oe", int'(oe_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_status", int'(status_a), 0);
      clr_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      chk("idle_tick_shift_en", int'(sh_seen), 0);
      chk("idle_tick_phase", int'(phase_a), 0);
      chk("idle_tick_idx", int'(idx_a), 0);

      foreach (vt[v]) begin
         sel = vt[v].sel;
         rnw = vt[v].rnw;
         ack = vt[v].ack;
         step(1'b0, !vt[v].sel, vt[v].sel);
         chk($sformatf("v%0d_accept_phase", v), int'(phase_m), 1);
         chk($sformatf("v%0d_accept_busy", v), int'(busy_m), 1);
         chk($sformatf("v%0d_accept_idx", v), int'(idx_m), 0);
         rnw = !vt[v].rnw;
         run_to_done(ticks, seq, oe, sh, trnmax, got);
         chk($sformatf("v%0d_done_seen", v), int'(got), 1);
         chk($sformatf("v%0d_ticks", v), ticks, vt[v].ticks);
         chk($sformatf("v%0d_phase_seq", v), int'(seq), int'(vt[v].seq));
         chk($sformatf("v%0d_oe_ticks", v), oe, vt[v].oe);
         chk($sformatf("v%0d_shift_ticks", v), sh, vt[v].sh);
         chk($sformatf("v%0d_trn_max_idx", v), trnmax, vt[v].trnmax);
         chk($sformatf("v%0d_done_busy", v), int'(busy_m), 0);
         chk($sformatf("v%0d_status", v), int'(status_m), int'(vt[v].status));
         ack = 3'b111;
         step(1'b0, 1'b0, 1'b0);
         chk($sformatf("v%0d_done_width", v), int'(done_m), 0);
         step(1'b1, 1'b0, 1'b0);
         chk($sformatf("v%0d_status_hold", v), int'(status_m), int'(vt[v].status));
      end

      // start coinciding with a tick, then start while busy
      sel = 1'b0; rnw = 1'b1; ack = 3'b001;
      step(1'b1, 1'b1, 1'b0);
      chk("st_tick_phase", int'(phase_a), 1);
      chk("st_tick_idx", int'(idx_a), 0);
      step(1'b1, 1'b0, 1'b0);
      chk("st_tick_first_bit", int'(idx_a), 1);
      step(1'b0, 1'b1, 1'b0);
      chk("busy_start_phase", int'(phase_a), 1);
      chk("busy_start_idx", int'(idx_a), 1);
      run_to_done(ticks, seq, oe, sh, trnmax, got);
      chk("st_tick_done", int'(got), 1);
      chk("st_tick_remaining", ticks, 45);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("no_queue_busy", int'(busy_a), 0);
      chk("no_queue_phase", int'(phase_a), 0);

      // start accepted in the done cycle
      rnw = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      run_to_done(ticks, seq, oe, sh, trnmax, got);
      chk("b2b_first_done", int'(done_a), 1);
      rnw = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      chk("b2b_accept_phase", int'(phase_a), 1);
      chk("b2b_accept_busy", int'(busy_a), 1);
      run_to_done(ticks, seq, oe, sh, trnmax, got);
      chk("b2b_ticks", ticks, 46);
      chk("b2b_seq", int'(seq), int'(32'h1235670));

      // reset in the middle of the data phase
      step(1'b0, 1'b1, 1'b0);
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         if (phase_a == 3'd5 && idx_a == 6'd17) reached = 1'b1;
         else step(1'b1, 1'b0, 1'b0);
      end
      chk("mid_data_reached", int'(reached), 1);
      #2;
      clr_n = 1'b0;
      #1;
      chk("async_rst_phase", int'(phase_a), 0);
      chk("async_rst_idx", int'(idx_a), 0);
      chk("async_rst_busy", int'(busy_a), 0);
      chk("async_rst_oe", int'(oe_a), 0);
      chk("async_rst_status", int'(status_a), 0);
      @(posedge clk);
      #1;
      chk("async_rst_no_done", int'(done_a), 0);
      clr_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      chk("post_rst_no_done", int'(done_a), 0);
      step(1'b0, 1'b1, 1'b0);
      run_to_done(ticks, seq, oe, sh, trnmax, got);
      chk("post_rst_ticks", ticks, 46);
      chk("post_rst_status", int'(status_a), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
